pbkdf2_2: RTL and testbench
===========================

Name: pbkdf2_2

Overview:
Final PBKDF2-HMAC-SHA256 stage of the scrypt pipeline. It is the consumer end of the pbkdf2_1 datapath: it reuses the ipad/opad key midstates (ixor_hash/oxor_hash) that pbkdf2_1 already computed from the 80-byte header. Salt is the 1024-bit ROMix output; result is one 256-bit key (dkLen = 32, single block index).
The block drives its own sha256_core_standard instance through 4 compressions under an internal FSM, with a start/done handshake to the scheduler.

Parameters:
- BLK_INDEX, 32'h00000001, PBKDF2 block index appended to the salt.
- INNER_LEN, 64'h620, inner message bit length: 64 B ipad + 128 B salt + 4 B index.
- OUTER_LEN, 64'h300, outer message bit length: 64 B opad + 32 B inner digest.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only when ready=1
- ready  out  1  idle and able to accept start
- ixor_hash  in  256  SHA256 midstate after the (key^ipad) block
- oxor_hash  in  256  SHA256 midstate after the (key^opad) block
- salt_in  in  1024  ROMix output, SHA byte order; [1023:512] are the first 64 bytes
- done  out  1  one-cycle pulse when digest is valid
- digest  out  256  PBKDF2 result; holds its value until the next done
- busy  out  1  a job is in flight (equals ~ready)

Behaviour:
- Reset values: ready=1, busy=0, done=0, digest=0, state=IDLE, all internal registers 0, core init=0.
- Capture: on start&&ready, register ixor_hash, oxor_hash and salt_in. Inputs may change afterwards.
- Core use: first_block tied 0 (always continue from prev_digest). init is a single-cycle pulse in the first cycle of each compute state. block_in and prev_digest stay stable, as a function of state, until digest_valid.
- FSM states: IDLE, I0, I1, I2, O0, FIN.
  - IDLE -> I0 on accepted start.
  - I0: block = salt[1023:512], prev = ixor. On digest_valid, mem <= digest, go to I1.
  - I1: block = salt[511:0], prev = mem. On digest_valid, mem <= digest, go to I2.
  - I2: block = {BLK_INDEX, 32'h80000000, 384'h0, INNER_LEN}, prev = mem. On digest_valid, mem <= digest, go to O0.
  - O0: block = {mem, 32'h80000000, 160'h0, OUTER_LEN}, prev = oxor. On digest_valid, digest <= core digest, go to FIN.
  - FIN: done=1 for exactly one cycle, then IDLE with ready=1.
- Latency: with L = core cycles from init to digest_valid, start-accept to done = 4*(L+1)+1 cycles. Next start is accepted the cycle after done.
- Boundaries:
  - start while busy is ignored; no queueing.
  - digest_valid outside I0..O0, or before the init of the current state has issued, is ignored.
  - start and done never coincide, because ready=0 in FIN.
  - reset mid-job: immediate return to the reset values. The partial result is lost and digest reads 0.
  - Internal mem is not cleared between jobs; it is always overwritten before being read.

Optional Feature:
- PBKDF2_2_TARGET_CMP_EN
  - Defined: adds input target[255:0] (captured at start) and output hit[1].
  - hit is computed in O0 from the core digest as unsigned digest < target (big-endian 256-bit compare).
  - hit is registered alongside digest, so it is valid at done and held with digest. Reset value 0.
  - Undefined: neither port exists and no comparator is built.

Decomposition:
- Shared package pbkdf2_pkg: ipad/opad constants, SHA pad word 32'h80000000, INNER_LEN/OUTER_LEN, state encoding, 512/256 width constants. pbkdf2_1_dp uses the same constants.
- One sub-module, pbkdf2_2_fsm:
  - owns state, the init pulse, done/ready, and the select outputs for the block/prev muxes and register-load enables.
  - the top holds the capture registers, mem, muxes and core instance (mux21/mux41 reused).

Test Plan:
- Reset: hold reset_n=0 -> ready=1, done=0, digest=0, init=0; release with no start -> no change for 100 cycles.
- Single job: random header through a software pbkdf2_1 model to get ixor/oxor, random salt, start -> 4 init pulses spaced L+1 apart, done after 4*(L+1)+1 cycles, digest equals the Python hashlib PBKDF2(header, salt, 1, 32) result.
- Block contents: at the I2 init, block_in == {32'h1, 32'h80000000, 384'h0, 64'h620}; at the O0 init, prev_digest == oxor and block_in[255:0] == {32'h80000000, 160'h0, 64'h300}.
- Start while busy plus input change: pulse start again mid-I1 with a different salt_in -> ignored, digest matches the first salt. Back-to-back start the cycle after done is accepted.
- Reset mid-job: assert reset_n=0 during O0 -> digest=0 and ready=1 immediately. A new job afterwards gives the correct digest.
- Target compare (macro on): target=256'hFFFF...F -> hit=1; target=0 -> hit=0; target=digest -> hit=0; target=digest+1 -> hit=1.

Source files
------------

// File: rtl/pbkdf2_pkg.sv
// Shared constants and encodings for the PBKDF2-HMAC-SHA256 stages of the scrypt pipeline.
package pbkdf2_pkg;

    localparam int unsigned BLOCK_W  = 512;
    localparam int unsigned DIGEST_W = 256;

    localparam logic [BLOCK_W-1:0] IPAD = {64{8'h36}};
    localparam logic [BLOCK_W-1:0] OPAD = {64{8'h5c}};

    localparam logic [31:0] SHA_PAD   = 32'h8000_0000;
    localparam logic [31:0] BLK_INDEX = 32'h0000_0001;
    localparam logic [63:0] INNER_LEN = 64'h620;
    localparam logic [63:0] OUTER_LEN = 64'h300;

    typedef enum logic [2:0] {StIdle, StI0, StI1, StI2, StO0, StFin} pbkdf2_2_state_t;
    typedef enum logic [1:0] {BlkSaltHi, BlkSaltLo, BlkIndex, BlkOuter} blk_sel_t;
    typedef enum logic [1:0] {PrevIxor, PrevMem, PrevOxor} prev_sel_t;

    function automatic logic is_compute(input pbkdf2_2_state_t s);
        return (s == StI0) || (s == StI1) || (s == StI2) || (s == StO0);
    endfunction

endpackage

// File: rtl/pbkdf2_2_fsm.sv
// Sequencer for pbkdf2_2: walks I0, I1, I2, O0, issuing one core init per state and
// steering the block/prev muxes and register loads.
module pbkdf2_2_fsm import pbkdf2_pkg::*; (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      start,
    input  logic      digest_valid,
    output logic      ready,
    output logic      busy,
    output logic      done,
    output logic      init,
    output logic      capture,
    output logic      mem_load,
    output logic      digest_load,
    output blk_sel_t  blk_sel,
    output prev_sel_t prev_sel
);

    pbkdf2_2_state_t state_q, state_d;
    logic            first_q;
    logic            step;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= (state_d != state_q) && is_compute(state_d);
        end
    end

    // A valid seen in the init cycle belongs to an earlier compression.
    assign step = digest_valid && !first_q;
    assign busy = ~ready;

    always_comb begin
        state_d     = state_q;
        ready       = 1'b0;
        done        = 1'b0;
        init        = 1'b0;
        capture     = 1'b0;
        mem_load    = 1'b0;
        digest_load = 1'b0;
        blk_sel     = BlkSaltHi;
        prev_sel    = PrevIxor;
        case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (start) begin
                    capture = 1'b1;
                    state_d = StI0;
                end
            end
            StI0: begin
                init = first_q;
                if (step) begin
                    mem_load = 1'b1;
                    state_d  = StI1;
                end
            end
            StI1: begin
                init     = first_q;
                blk_sel  = BlkSaltLo;
                prev_sel = PrevMem;
                if (step) begin
                    mem_load = 1'b1;
                    state_d  = StI2;
                end
            end
            StI2: begin
                init     = first_q;
                blk_sel  = BlkIndex;
                prev_sel = PrevMem;
                if (step) begin
                    mem_load = 1'b1;
                    state_d  = StO0;
                end
            end
            StO0: begin
                init     = first_q;
                blk_sel  = BlkOuter;
                prev_sel = PrevOxor;
                if (step) begin
                    digest_load = 1'b1;
                    state_d     = StFin;
                end
            end
            StFin: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: rtl/sha256_core_standard.sv
// Iterative SHA-256 compression core: one round per cycle, digest_valid pulses 65 cycles
// after init with prev_digest (or the IV when first_block) added back in.
module sha256_core_standard (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic         first_block,
    input  logic [511:0] block_in,
    input  logic [255:0] prev_digest,
    output logic [255:0] digest,
    output logic         digest_valid
);

    localparam logic [255:0] SHA_IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    logic [7:0][31:0]  st_q, st_n, hv_q;  // index 0 is working variable a
    logic [15:0][31:0] w_q;               // sliding message-schedule window, w_q[0] = W[t]
    logic [5:0]        rnd_q;
    logic              run_q;
    logic [31:0]       t1, t2, w_new;
    logic [255:0]      start_h;

    assign start_h = first_block ? SHA_IV : prev_digest;

    always_comb begin
        t1 = st_q[7] + (rotr(st_q[4], 6) ^ rotr(st_q[4], 11) ^ rotr(st_q[4], 25))
           + ((st_q[4] & st_q[5]) ^ (~st_q[4] & st_q[6])) + K[rnd_q] + w_q[0];
        t2 = (rotr(st_q[0], 2) ^ rotr(st_q[0], 13) ^ rotr(st_q[0], 22))
           + ((st_q[0] & st_q[1]) ^ (st_q[0] & st_q[2]) ^ (st_q[1] & st_q[2]));
        st_n      = st_q;
        st_n[7:1] = st_q[6:0];
        st_n[0]   = t1 + t2;
        st_n[4]   = st_q[3] + t1;
        w_new = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
              + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q         <= '0;
            hv_q         <= '0;
            w_q          <= '0;
            rnd_q        <= '0;
            run_q        <= 1'b0;
            digest       <= '0;
            digest_valid <= 1'b0;
        end else begin
            digest_valid <= 1'b0;
            if (init) begin
                for (int i = 0; i < 8; i++) begin
                    st_q[i] <= start_h[255-32*i -: 32];
                    hv_q[i] <= start_h[255-32*i -: 32];
                end
                for (int i = 0; i < 16; i++) w_q[i] <= block_in[511-32*i -: 32];
                rnd_q <= '0;
                run_q <= 1'b1;
            end else if (run_q) begin
                st_q  <= st_n;
                w_q   <= {w_new, w_q[15:1]};
                rnd_q <= rnd_q + 6'd1;
                if (rnd_q == 6'd63) begin
                    run_q        <= 1'b0;
                    digest_valid <= 1'b1;
                    for (int i = 0; i < 8; i++) digest[255-32*i -: 32] <= hv_q[i] + st_n[i];
                end
            end
        end
    end

endmodule

// File: rtl/pbkdf2_2.sv
// Final PBKDF2-HMAC-SHA256 stage: salt = ROMix output, one 256-bit key from ipad/opad midstates.
// Optional PBKDF2_2_TARGET_CMP_EN adds a target input and a registered digest < target flag.
module pbkdf2_2 import pbkdf2_pkg::*; (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    output logic          ready,
    input  logic [255:0]  ixor_hash,
    input  logic [255:0]  oxor_hash,
    input  logic [1023:0] salt_in,
`ifdef PBKDF2_2_TARGET_CMP_EN
    input  logic [255:0]  target,
    output logic          hit,
`endif
    output logic          done,
    output logic [255:0]  digest,
    output logic          busy
);

    logic [DIGEST_W-1:0] ixor_q, oxor_q, mem_q;
    logic [1023:0]       salt_q;
    logic [BLOCK_W-1:0]  core_block;
    logic [DIGEST_W-1:0] core_prev, core_digest;
    logic                core_init, core_valid;
    logic                capture, mem_load, digest_load;
    blk_sel_t            blk_sel;
    prev_sel_t           prev_sel;

    pbkdf2_2_fsm u_fsm (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .digest_valid (core_valid),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .init         (core_init),
        .capture      (capture),
        .mem_load     (mem_load),
        .digest_load  (digest_load),
        .blk_sel      (blk_sel),
        .prev_sel     (prev_sel)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ixor_q <= '0;
            oxor_q <= '0;
            salt_q <= '0;
            mem_q  <= '0;
            digest <= '0;
        end else begin
            if (capture) begin
                ixor_q <= ixor_hash;
                oxor_q <= oxor_hash;
                salt_q <= salt_in;
            end
            if (mem_load)    mem_q  <= core_digest;
            if (digest_load) digest <= core_digest;
        end
    end

`ifdef PBKDF2_2_TARGET_CMP_EN
    logic [255:0] target_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            target_q <= '0;
            hit      <= 1'b0;
        end else begin
            if (capture)     target_q <= target;
            if (digest_load) hit      <= core_digest < target_q;
        end
    end
`endif

    always_comb begin
        core_block = '0;
        case (blk_sel)
            BlkSaltHi: core_block = salt_q[1023:512];
            BlkSaltLo: core_block = salt_q[511:0];
            BlkIndex:  core_block = {BLK_INDEX, SHA_PAD, 384'h0, INNER_LEN};
            BlkOuter:  core_block = {mem_q, SHA_PAD, 160'h0, OUTER_LEN};
            default:   core_block = '0;
        endcase
    end

    always_comb begin
        core_prev = ixor_q;
        case (prev_sel)
            PrevIxor: core_prev = ixor_q;
            PrevMem:  core_prev = mem_q;
            PrevOxor: core_prev = oxor_q;
            default:  core_prev = ixor_q;
        endcase
    end

    sha256_core_standard u_core (
        .clk          (clk),
        .reset_n      (reset_n),
        .init         (core_init),
        .first_block  (1'b0),
        .block_in     (core_block),
        .prev_digest  (core_prev),
        .digest       (core_digest),
        .digest_valid (core_valid)
    );

endmodule

// File: tb/tb_pbkdf2_2.sv
// Directed bench for pbkdf2_2: reference PBKDF2-HMAC-SHA256 built from a standalone SHA model.
module tb_pbkdf2_2;

    localparam int L        = 65;
    localparam int JOB_LAT  = 4 * (L + 1) + 1;
    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          ready, done, busy;
    logic [255:0]  ixor_hash = '0, oxor_hash = '0, digest;
    logic [1023:0] salt_in = '0;
`ifdef PBKDF2_2_TARGET_CMP_EN
    logic [255:0]  target = '0;
    logic          hit;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int job_lat, job_inits;
    bit job_space_ok;
    logic [255:0] prev_exp = '0;

    always #5 clk = ~clk;

    pbkdf2_2 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .ready     (ready),
        .ixor_hash (ixor_hash),
        .oxor_hash (oxor_hash),
        .salt_in   (salt_in),
`ifdef PBKDF2_2_TARGET_CMP_EN
        .target    (target),
        .hit       (hit),
`endif
        .done      (done),
        .digest    (digest),
        .busy      (busy)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    // PBKDF2(P, S, c=1, dkLen=32) = HMAC(P, S || INT(1)) given the two key midstates.
    function automatic logic [255:0] pbkdf2_ref(input logic [255:0] ix, input logic [255:0] ox,
                                                input logic [1023:0] s);
        logic [255:0] inner;
        inner = compress(ix, s[1023:512]);
        inner = compress(inner, s[511:0]);
        inner = compress(inner, {32'h1, 32'h80000000, 384'h0, 64'h620});
        return compress(ox, {inner, 32'h80000000, 160'h0, 64'h300});
    endfunction

    task automatic chkw(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one job; poke_at pulses a second start with a changed salt, rst_at resets mid-job.
    task automatic run_job(input logic [1023:0] s, input int poke_at, input int rst_at);
        int n, last;
        bit aborted;
        @(negedge clk);
        chk1("ready_idle", ready, 1'b1);
        chk1("done_single_cycle", done, 1'b0);
        chkw("digest_held", 512'(digest), 512'(prev_exp));
        salt_in = s;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1; last = 0; job_inits = 0; job_space_ok = 1'b1; aborted = 1'b0;
        while (!done && n < 2000 && !aborted) begin
            if (dut.core_init) begin
                if ((job_inits == 0 && n != 1) || (job_inits > 0 && n - last != L + 1))
                    job_space_ok = 1'b0;
                if (job_inits == 2)
                    chkw("i2_block", 512'(dut.core_block), {32'h1, 32'h80000000, 384'h0, 64'h620});
                if (job_inits == 3) begin
                    chkw("o0_prev", 512'(dut.core_prev), 512'(oxor_hash));
                    chkw("o0_block_tail", 512'(dut.core_block[255:0]),
                         512'({32'h80000000, 160'h0, 64'h300}));
                end
                job_inits++;
                last = n;
            end
            start = (n == poke_at);
            if (n == poke_at) begin
                salt_in = ~s;
                chk1("ready_low_busy", ready, 1'b0);
            end
            if (n == rst_at) begin
                reset_n = 1'b0;
                #1;
                chkw("rst_mid_digest", 512'(digest), 512'(0));
                chk1("rst_mid_ready", ready, 1'b1);
                chk1("rst_mid_busy", busy, 1'b0);
                @(negedge clk);
                reset_n  = 1'b1;
                prev_exp = '0;
                aborted  = 1'b1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        start   = 1'b0;
        job_lat = n;
        if (!aborted) chk1("ready_low_at_done", ready, 1'b0);
    endtask

    logic [639:0]  header;
    logic [255:0]  key, exp1, exp2, exp3;
    logic [1023:0] salt1, salt2, salt3;
    bit            idle_bad;

    initial begin
        // Reset state
        #3;
        chk1("rst_ready", ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chkw("rst_digest", 512'(digest), 512'(0));
        chk1("rst_init", dut.core_init, 1'b0);
        repeat (3) @(negedge clk);
        reset_n  = 1'b1;
        idle_bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || dut.core_init !== 1'b0 ||
                digest !== '0)
                idle_bad = 1'b1;
        end
        chk1("idle_100_stable", idle_bad, 1'b0);

        // Reference model anchored on the published SHA-256("abc") vector
        chkw("model_abc", 512'(compress(IV, {32'h61626380, 448'h0, 32'h18})),
             512'(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad));

        for (int i = 0; i < 20; i++) header[32*i +: 32] = $urandom;
        for (int i = 0; i < 32; i++) begin
            salt1[32*i +: 32] = $urandom;
            salt2[32*i +: 32] = $urandom;
            salt3[32*i +: 32] = $urandom;
        end
        key = compress(compress(IV, header[639:128]),
                       {header[127:0], 32'h80000000, 288'h0, 64'h280});
        ixor_hash = compress(IV, {key ^ {8{32'h36363636}}, {8{32'h36363636}}});
        oxor_hash = compress(IV, {key ^ {8{32'h5c5c5c5c}}, {8{32'h5c5c5c5c}}});
        exp1 = pbkdf2_ref(ixor_hash, oxor_hash, salt1);
        exp2 = pbkdf2_ref(ixor_hash, oxor_hash, salt2);
        exp3 = pbkdf2_ref(ixor_hash, oxor_hash, salt3);

        // Single job
        run_job(salt1, -1, -1);
        chki("job1_latency", job_lat, JOB_LAT);
        chki("job1_inits", job_inits, 4);
        chk1("job1_init_spacing", job_space_ok, 1'b1);
        chkw("job1_digest", 512'(digest), 512'(exp1));
        prev_exp = exp1;

        // Back-to-back start, with an ignored start and salt change during I1
        run_job(salt2, 80, -1);
        chki("job2_latency", job_lat, JOB_LAT);
        chkw("job2_digest", 512'(digest), 512'(exp2));
        prev_exp = exp2;

        // Reset during O0, then a clean job
        run_job(salt3, -1, 220);
        run_job(salt3, -1, -1);
        chki("job4_latency", job_lat, JOB_LAT);
        chkw("job4_digest", 512'(digest), 512'(exp3));
        prev_exp = exp3;

`ifdef PBKDF2_2_TARGET_CMP_EN
        target = '1;
        run_job(salt1, -1, -1);
        chk1("hit_target_max", hit, 1'b1);
        prev_exp = exp1;
        target = '0;
        run_job(salt1, -1, -1);
        chk1("hit_target_zero", hit, 1'b0);
        target = exp1;
        run_job(salt1, -1, -1);
        chk1("hit_target_eq", hit, 1'b0);
        target = exp1 + 256'd1;
        run_job(salt1, -1, -1);
        chk1("hit_target_eq_plus1", hit, 1'b1);
        chkw("hit_job_digest", 512'(digest), 512'(exp1));
`endif

        repeat (3) @(negedge clk);
        chkw("digest_held_end", 512'(digest), 512'(prev_exp));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
